// File: rtl/iobuf_bus_sequencer_pkg.sv
// Shared types and constants for the pad-bus sequencer and its arbiter.
package iobuf_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TURN = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam int REQ0  = 0;
  localparam int REQ1  = 1;

  function automatic logic [1:0] onehot2(input logic idx);
    onehot2 = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/iobuf_bus_sequencer_if.sv
// Requester handshake plus pad-ring signals of the shared bidirectional bus.
interface iobuf_bus_sequencer_if #(
  parameter int DW = 8
);
  logic [1:0]    req;
  logic [1:0]    wr;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] pad_o;
  logic          pad_t;
  logic [DW-1:0] pad_i;

  // master: requesters and pad ring; slave: the sequencer
  modport master (
    output req, wr, wdata0, wdata1, pad_i,
    input  gnt, done, rd_data, pad_o, pad_t
  );

  modport slave (
    input  req, wr, wdata0, wdata1, pad_i,
    output gnt, done, rd_data, pad_o, pad_t
  );
endinterface

// File: rtl/iobuf_bus_sequencer_rr_arb2.sv
// Two-requester round-robin picker; combinational pick, last_winner updated on advance.
// A tie goes to the requester that did not win last time.
module rr_arb2
  import iobuf_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       winner,
  output logic       winner_valid
);

  logic last_winner;

  always_comb begin
    winner_valid = req[REQ0] | req[REQ1];
    if (req[REQ0] && req[REQ1]) begin
      winner = ~last_winner;
    end else begin
      winner = req[REQ1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= 1'b1;
    end else if (advance) begin
      last_winner <= winner;
    end
  end

endmodule

// File: rtl/iobuf_bus_sequencer.sv
// Shares one tri-state pad bus between two requesters: grant, DRIVE_CYC data cycles, TURN_CYC released cycles.
// gnt spans cycles 1..DRIVE_CYC+TURN_CYC after the request edge; done pulses in the last one; no backpressure beyond req/gnt.
module iobuf_bus_sequencer
  import iobuf_seq_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DRIVE_CYC = 2,
  parameter int TURN_CYC  = 1
) (
  input logic                  clk,
  input logic                  rst,
  iobuf_bus_sequencer_if.slave bus
);

  if (DRIVE_CYC < 1 || DRIVE_CYC > 15) begin : g_bad_drive
    $error("DRIVE_CYC must be within 1..15");
  end
  if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn
    $error("TURN_CYC must be within 1..15");
  end

  localparam logic [CNT_W-1:0] DRV_LD = CNT_W'(DRIVE_CYC - 1);
  localparam logic [CNT_W-1:0] TRN_LD = CNT_W'(TURN_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic             win_q;
  logic             winner;
  logic             winner_valid;
  logic             advance;
  logic [DW-1:0]    wsel;

  assign advance = (state == IDLE) && winner_valid;
  assign wsel    = winner ? bus.wdata1 : bus.wdata0;

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (bus.req),
    .advance      (advance),
    .winner       (winner),
    .winner_valid (winner_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      win_q       <= 1'b0;
      bus.gnt     <= 2'b00;
      bus.done    <= 2'b00;
      bus.rd_data <= '0;
      bus.pad_o   <= '0;
      bus.pad_t   <= 1'b1;
    end else begin
      bus.done <= 2'b00;
      case (state)
        IDLE: begin
          if (winner_valid) begin
            wr_q      <= bus.wr[winner];
            win_q     <= winner;
            bus.pad_o <= wsel;
            bus.pad_t <= ~bus.wr[winner];
            bus.gnt   <= onehot2(winner);
            cnt       <= DRV_LD;
            state     <= DATA;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            if (!wr_q) begin
              bus.rd_data <= bus.pad_i;
            end
            bus.pad_t <= 1'b1;
            bus.pad_o <= '0;
            cnt       <= TRN_LD;
            state     <= TURN;
            // done is registered, so it is raised on the edge entering the last TURN cycle
            if (TURN_CYC == 1) begin
              bus.done <= onehot2(win_q);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        TURN: begin
          if (cnt == '0) begin
            bus.gnt <= 2'b00;
            state   <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              bus.done <= onehot2(win_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
